vedic_mult_pipe: RTL

//  Parametrised, pipelined signed/unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.

---
 rtl/vedic_mult_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vedic_mult_pipe.sv
// Pipelined signed/unsigned Urdhva-Tiryagbhyam multiplier with valid/ready on both sides.
// Stage 1 registers operand magnitudes and the product sign. Stage 2 forms the 2x2
// crosswise products and the first merge. Every later stage merges one more Vedic level.
// The final stage performs the last merge and restores the sign.
// Optional feature: define VEDIC_FLUSH_EN to add a synchronous 'flush' input that
// drops every in-flight product.
// WIDTH must be a power of two between 4 and 64.

module vedic_mult_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef VEDIC_FLUSH_EN
  input  logic               flush,
`endif
  output logic [2*WIDTH-1:0] out,
  output logic               out_signed
);

  localparam int unsigned LAT = $clog2(WIDTH);
  // Registered intermediate levels 2..LAT-1 are packed back to back in one vector.
  // Their total size is W^2 - 4W bits. The vector is 1 bit wide when no such level exists.
  localparam int unsigned PP_W = (LAT > 2) ? (WIDTH * WIDTH - 4 * WIDTH) : 1;

  // Bit offset of level k, which holds 2^k x 2^k products, inside pp_q/pp_d.
  function automatic int unsigned lvl_off(input int unsigned k);
    return WIDTH * WIDTH - ((WIDTH * WIDTH) >> (k - 2));
  endfunction

  // Total width of level k: (W/2^k)^2 products of 2^(k+1) bits each.
  function automatic int unsigned lvl_w(input int unsigned k);
    return (2 * WIDTH * WIDTH) >> k;
  endfunction

  // 2x2 vertical-and-crosswise product built from half adders.
  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic       cross_c;
    logic [3:0] p;
    p[0]    = x[0] & y[0];
    p[1]    = (x[1] & y[0]) ^ (x[0] & y[1]);
    cross_c = x[1] & y[0] & x[0] & y[1];
    p[2]    = (x[1] & y[1]) ^ cross_c;
    p[3]    = x[1] & y[1] & cross_c;
    return p;
  endfunction

  logic                   do_flush;
  logic                   adv;
  logic                   accept;
  logic [WIDTH-1:0]       mag_a_d, mag_b_d;
  logic [WIDTH-1:0]       mag_a_q, mag_b_q;
  logic                   neg_d;
  logic [LAT:1]           vld_q;
  logic [LAT:1]           sgn_q;
  logic [LAT-1:1]         neg_q;
  logic [WIDTH*WIDTH-1:0] lvl1;
  logic [PP_W-1:0]        pp_d, pp_q;
  logic [2*WIDTH-1:0]     top;
  logic [2*WIDTH-1:0]     out_d, out_q;

`ifdef VEDIC_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  // Handshake and stage-1 operand conditioning.
  always_comb begin
    adv      = !vld_q[LAT] | out_ready;
    in_ready = adv & !do_flush;
    accept   = in_valid & in_ready;
    // The magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
    mag_a_d  = (in_signed && a[WIDTH-1]) ? -a : a;
    mag_b_d  = (in_signed && b[WIDTH-1]) ? -b : b;
    neg_d    = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // Level 1: all 2x2 digit products of the registered magnitudes.
  for (genvar i = 0; i < WIDTH / 2; i++) begin : g_base_i
    for (genvar j = 0; j < WIDTH / 2; j++) begin : g_base_j
      assign lvl1[(i * (WIDTH / 2) + j) * 4 +: 4] =
          vedic2x2(mag_a_q[2 * i +: 2], mag_b_q[2 * j +: 2]);
    end
  end

  // Level k merges four half-size products into each 2^k x 2^k product:
  // {hh, ll} + (hl + lh) << half.
  for (genvar k = 2; k <= LAT; k++) begin : g_lvl
    localparam int unsigned N  = 1 << k;
    localparam int unsigned H  = N / 2;
    localparam int unsigned M  = WIDTH / N;
    localparam int unsigned SM = 2 * M;

    logic [SM*SM*N-1:0] src;
    logic [M*M*2*N-1:0] res;

    if (k == 2) begin : g_src_base
      assign src = lvl1;
    end else begin : g_src_reg
      localparam int unsigned SRC_OFF = lvl_off(k - 1);
      assign src = pp_q[SRC_OFF +: lvl_w(k - 1)];
    end

    for (genvar i = 0; i < M; i++) begin : g_blk_i
      for (genvar j = 0; j < M; j++) begin : g_blk_j
        logic [N-1:0] hh, hl, lh, ll;
        assign hh = src[((2 * i + 1) * SM + 2 * j + 1) * N +: N];
        assign hl = src[((2 * i + 1) * SM + 2 * j) * N +: N];
        assign lh = src[((2 * i) * SM + 2 * j + 1) * N +: N];
        assign ll = src[((2 * i) * SM + 2 * j) * N +: N];
        assign res[(i * M + j) * 2 * N +: 2 * N] =
            {hh, ll} + ({{(N - 1){1'b0}}, ({1'b0, hl} + {1'b0, lh})} << H);
      end
    end

    if (k < LAT) begin : g_mid
      assign pp_d[lvl_off(k) +: lvl_w(k)] = res;
    end else begin : g_last
      assign top = res;
    end
  end

  if (LAT == 2) begin : g_no_mid
    assign pp_d = '0;
  end

  // Final stage restores the sign. Negating zero yields zero, so no negative zero is produced.
  always_comb begin
    out_d = neg_q[LAT-1] ? -top : top;
  end

  // Pipeline registers: a flush drops every valid bit, and a stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      sgn_q   <= '0;
      neg_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      pp_q    <= '0;
      out_q   <= '0;
    end else if (do_flush) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q    <= {vld_q[LAT-1:1], accept};
      sgn_q    <= {sgn_q[LAT-1:1], in_signed};
      neg_q[1] <= neg_d;
      for (int unsigned s = 2; s < LAT; s++) begin
        neg_q[s] <= neg_q[s-1];
      end
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      pp_q    <= pp_d;
      out_q   <= out_d;
    end
  end

  assign out_valid  = vld_q[LAT];
  assign out_signed = sgn_q[LAT];
  assign out        = out_q;

endmodule
